// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//   master modport : requester side (drives req/we/addr/wdata/be/lock,
//                    receives gnt/rvalid/rdata/err)
//   slave modport  : arbiter side (mirror of master)
// lock is only honoured on the m1 port; the m0 requester ties it low.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    lock;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, we, addr, wdata, be, lock,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be, lock,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the core data memory between the core load/store
// port (m0) and the debug/loader port (m1). Round-robin arbitration, m1 may
// lock m0 out for burst loads, byte enables are alignment-checked, and load
// data / alignment errors return to the requester exactly one cycle later.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   m0, m1       : requester ports (dmem_arbiter_if.slave)
//   mem_en/we/addr/wdata/be : granted access to memory (zero when idle)
//   mem_rdata    : memory read data, valid one cycle after a load access
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  dmem_arbiter_if.slave           m0,
  dmem_arbiter_if.slave           m1,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_M0   = 2'd1,
    RESP_M1   = 2'd2
  } resp_sel_e;

  typedef enum logic {
    KIND_READ = 1'b0,
    KIND_ERR  = 1'b1
  } resp_kind_e;

  logic       prio_q, prio_d;       // 0: m0 preferred on a tie
  logic       locked_q, locked_d;
  resp_sel_e  resp_sel_q, resp_sel_d;
  resp_kind_e resp_kind_q, resp_kind_d;

  logic                  gnt0, gnt1, any_gnt, legal;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]       sel_be;

  function automatic logic be_aligned(input logic [BE_W-1:0] be,
                                      input logic [1:0]      off);
    case (be)
      4'hF, 4'h3: return off == 2'd0;
      4'hC:       return off == 2'd2;
      4'h1:       return off == 2'd0;
      4'h2:       return off == 2'd1;
      4'h4:       return off == 2'd2;
      4'h8:       return off == 2'd3;
      default:    return 1'b0;
    endcase
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      // While locked m0 is never eligible; otherwise prio breaks the tie.
      gnt0 = m0.req && !locked_q && (!m1.req || !prio_q);
      gnt1 = m1.req && !gnt0;
    end
    any_gnt = gnt0 || gnt1;

    sel_we    = gnt1 ? m1.we    : m0.we;
    sel_addr  = gnt1 ? m1.addr  : m0.addr;
    sel_wdata = gnt1 ? m1.wdata : m0.wdata;
    sel_be    = gnt1 ? m1.be    : m0.be;
    legal     = be_aligned(sel_be, sel_addr[1:0]);

    mem_en    = any_gnt && legal;
    mem_we    = mem_en ? sel_we    : 1'b0;
    mem_addr  = mem_en ? sel_addr  : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
    mem_be    = mem_en ? sel_be    : '0;

    prio_d      = prio_q;
    locked_d    = locked_q;
    resp_sel_d  = RESP_NONE;
    resp_kind_d = KIND_READ;

    if (any_gnt) begin
      // The master just served drops to lowest priority.
      prio_d = gnt0;
      if (!legal) begin
        resp_sel_d  = gnt0 ? RESP_M0 : RESP_M1;
        resp_kind_d = KIND_ERR;
      end else if (!sel_we) begin
        resp_sel_d  = gnt0 ? RESP_M0 : RESP_M1;
        resp_kind_d = KIND_READ;
      end
    end
    // Lock follows every m1 grant, aligned or not.
    if (gnt1) begin
      locked_d = m1.lock;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q      <= 1'b0;
      locked_q    <= 1'b0;
      resp_sel_q  <= RESP_NONE;
      resp_kind_q <= KIND_READ;
    end else begin
      prio_q      <= prio_d;
      locked_q    <= locked_d;
      resp_sel_q  <= resp_sel_d;
      resp_kind_q <= resp_kind_d;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = (resp_sel_q == RESP_M0) && (resp_kind_q == KIND_READ);
  assign m1.rvalid = (resp_sel_q == RESP_M1) && (resp_kind_q == KIND_READ);
  assign m0.err    = (resp_sel_q == RESP_M0) && (resp_kind_q == KIND_ERR);
  assign m1.err    = (resp_sel_q == RESP_M1) && (resp_kind_q == KIND_ERR);
  assign m0.rdata  = m0.rvalid ? mem_rdata : '0;
  assign m1.rdata  = m1.rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by random traffic on both
// ports. A reference model predicts grants, memory-bus contents and
// responses; responses go into per-master queues that a separate monitor
// drains one cycle later.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int unsigned due;
    bit          is_err;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 3) ? 32'hBBBB_BBBB : 32'h0101_0101 * (i + 1);
  endfunction

  // 16-word memory behind the arbiter; reloaded while reset is high.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr[5:2]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:2]];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [16];
  bit          m0_turn;
  bit          lock_held;
  resp_t       q0[$];
  resp_t       q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [3:0] be, input logic [1:0] off);
    return (be == 4'hF && off == 0) || (be == 4'h3 && off == 0) ||
           (be == 4'hC && off == 2) || (be == (4'h1 << off));
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m0_turn   = 1'b1;
    lock_held = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
  endtask

  function automatic req_t mk(input logic r, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    req_t x;
    x.req = r; x.we = we; x.addr = a; x.wdata = d; x.be = be;
    return x;
  endfunction

  function automatic req_t rand_req();
    req_t x;
    x.req   = ($urandom_range(0, 9) < 7);
    x.we    = 1'($urandom_range(0, 1));
    x.addr  = 32'($urandom_range(0, 63));
    x.wdata = $urandom;
    case ($urandom_range(0, 4))
      0: begin x.be = 4'hF; x.addr[1:0] = 2'd0; end
      1: begin x.be = 4'h3; x.addr[1:0] = 2'd0; end
      2: begin x.be = 4'hC; x.addr[1:0] = 2'd2; end
      3: x.be = 4'h1 << x.addr[1:0];
      default: x.be = 4'($urandom_range(0, 15));
    endcase
    return x;
  endfunction

  // One clock cycle: drive at posedge+1, check the combinational response
  // at negedge and let the model predict what comes next.
  task automatic step(input req_t s0, input req_t s1, input bit lk,
                      input bit rst, output int w);
    req_t  g;
    bit    legal, exp_en;
    resp_t r;
    @(posedge clk);
    #1;
    reset        = rst;
    m0_if.req    = s0.req;  m0_if.we = s0.we;  m0_if.addr = s0.addr;
    m0_if.wdata  = s0.wdata; m0_if.be = s0.be; m0_if.lock = 1'b0;
    m1_if.req    = s1.req;  m1_if.we = s1.we;  m1_if.addr = s1.addr;
    m1_if.wdata  = s1.wdata; m1_if.be = s1.be; m1_if.lock = lk;
    if (rst) model_reset();
    @(negedge clk);
    w = -1;
    if (!rst) begin
      if (lock_held)            w = s1.req ? 1 : -1;
      else if (s0.req && s1.req) w = m0_turn ? 0 : 1;
      else if (s0.req)           w = 0;
      else if (s1.req)           w = 1;
    end
    check("gnt", {m1_if.gnt, m0_if.gnt}, {(w == 1), (w == 0)});
    g      = (w == 1) ? s1 : s0;
    legal  = ref_legal(g.be, g.addr[1:0]);
    exp_en = (w >= 0) && legal;
    check("mem_en", mem_en, exp_en);
    if (w < 0 || exp_en)
      check("mem_bus", {mem_we, mem_addr, mem_wdata, mem_be},
            exp_en ? {g.we, g.addr, g.wdata, g.be} : 69'd0);
    if (w >= 0) begin
      r.due = cyc + 1;
      r.is_err = !legal;
      r.data = '0;
      if (legal && !g.we) r.data = ref_mem[g.addr[5:2]];
      if (legal && g.we) begin
        for (int i = 0; i < 4; i++)
          if (g.be[i]) ref_mem[g.addr[5:2]][i*8 +: 8] = g.wdata[i*8 +: 8];
      end else begin
        if (w == 0) q0.push_back(r); else q1.push_back(r);
      end
      m0_turn = (w == 1);
      if (w == 1) lock_held = lk;
    end
  endtask

  // Monitor: each cycle, whatever is due must show up, and nothing else.
  task automatic mon_port(input int p, input logic rv, input logic er,
                          input logic [31:0] rd);
    bit    due = 0;
    resp_t e;
    e.is_err = 0; e.data = '0; e.due = 0;
    if (p == 0 && q0.size() > 0 && q0[0].due <= cyc) begin due = 1; e = q0.pop_front(); end
    if (p == 1 && q1.size() > 0 && q1[0].due <= cyc) begin due = 1; e = q1.pop_front(); end
    check(p == 0 ? "m0_resp" : "m1_resp", {rv, er, rd},
          {(due && !e.is_err), (due && e.is_err), (due && !e.is_err) ? e.data : 32'd0});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon_port(0, m0_if.rvalid, m0_if.err, m0_if.rdata);
      mon_port(1, m1_if.rvalid, m1_if.err, m1_if.rdata);
    end
  end

  initial begin
    req_t z, s0, s1, a;
    bit   lk;
    int   w;
    z = '0;
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.be = '0; m0_if.lock = 0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.be = '0; m1_if.lock = 0;
    model_reset();

    // Reset state with both masters requesting: no grant, no bus activity.
    step(mk(1, 0, 0, 0, 4'hF), mk(1, 0, 4, 0, 4'hF), 0, 1, w);
    step(mk(1, 0, 0, 0, 4'hF), mk(1, 0, 4, 0, 4'hF), 0, 1, w);

    // Round-robin: continuous loads from both, expect m0, m1, m0, m1.
    for (int i = 0; i < 4; i++)
      step(mk(1, 0, 32'h0, 0, 4'hF), mk(1, 0, 32'h4, 0, 4'hF), 0, 0, w);

    // Single m0 load of word 3.
    step(mk(1, 0, 32'hC, 0, 4'hF), z, 0, 0, w);
    step(z, z, 0, 0, w);

    // Lock burst: m0 is held out for all three m1 stores.
    step(mk(1, 0, 32'hC, 0, 4'hF), z, 0, 0, w);
    a = mk(1, 0, 32'h10, 0, 4'hF);
    step(a, mk(1, 1, 32'h0, 32'h1111_1111, 4'hF), 1, 0, w);
    step(a, mk(1, 1, 32'h4, 32'h2222_2222, 4'hF), 1, 0, w);
    step(a, mk(1, 1, 32'h8, 32'h3333_3333, 4'hF), 0, 0, w);
    step(a, z, 0, 0, w);

    // Misaligned word store, then a legal byte store.
    step(mk(1, 1, 32'h6, 32'hDEAD_BEEF, 4'hF), z, 0, 0, w);
    step(mk(1, 1, 32'h8, 32'h0000_005A, 4'h1), z, 0, 0, w);

    // Store then load of the same word from the other master.
    step(mk(1, 1, 32'h4, 32'hAAAA_AAAA, 4'hF), z, 0, 0, w);
    step(z, mk(1, 0, 32'h4, 0, 4'hF), 0, 0, w);
    step(z, z, 0, 0, w);

    // Reset right after a locking m1 load grant: no rvalid may follow.
    step(z, mk(1, 0, 32'hC, 0, 4'hF), 1, 0, w);
    #1;
    reset = 1'b1;
    model_reset();
    step(mk(1, 0, 0, 0, 4'hF), mk(1, 0, 4, 0, 4'hF), 0, 1, w);
    step(mk(1, 0, 0, 0, 4'hF), mk(1, 0, 4, 0, 4'hF), 0, 0, w);
    step(z, z, 0, 0, w);

    // Random traffic; a pending request keeps its payload until granted.
    s0 = rand_req();
    s1 = rand_req();
    lk = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      step(s0, s1, lk, 0, w);
      if (w == 0 || !s0.req) s0 = rand_req();
      if (w == 1 || !s1.req) begin
        s1 = rand_req();
        lk = ($urandom_range(0, 3) == 0);
      end
    end

    step(z, z, 0, 0, w);
    step(z, z, 0, 0, w);
    check("drain", 128'(q0.size() + q1.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle core's data memory between the core load/store port (m0) and a debug/loader port (m1). Program and data images are loaded through m1 while the core runs or stalls, instead of being written into memory directly. Arbitration is round-robin. m1 can lock the memory for burst loads. Byte enables are alignment-checked, and each read is routed back to its requester with fixed one-cycle latency.

## Interface

Parameters:
- ADDR_WIDTH, 32: byte address width on both masters and memory.
- DATA_WIDTH, 32: data width; byte-enable width is DATA_WIDTH/8, fixed at 4 for this core.

Ports (mX applies to both m0 and m1):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mX_req  in  1  request valid; held until mX_gnt.
- mX_we  in  1  1 = store, 0 = load.
- mX_addr  in  ADDR_WIDTH  byte address.
- mX_wdata  in  DATA_WIDTH  store data, already lane-aligned.
- mX_be  in  4  byte enables.
- m1_lock  in  1  sampled with a granted m1 request; 1 = keep m0 locked out.
- mX_gnt  out  1  request accepted this cycle (combinational).
- mX_rvalid  out  1  read data valid; one cycle after a granted aligned load.
- mX_rdata  out  DATA_WIDTH  equals mem_rdata while mX_rvalid is high, else 0.
- mX_err  out  1  one cycle after a granted misaligned request.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  granted address.
- mem_wdata  out  DATA_WIDTH  granted store data.
- mem_be  out  4  granted byte enables.
- mem_rdata  in  DATA_WIDTH  valid one cycle after mem_en with mem_we=0.

## Operation

State:
- prio (1 bit): 0 means m0 has priority. After a grant, the granted master gets lowest priority, so prio is set to 1 after an m0 grant and to 0 after an m1 grant.
- locked (1 bit).
- resp_sel (2 bits): none, m0 or m1.
- resp_kind (1 bit): read or error.

Grant rules:
- If locked, only m1 is eligible.
- Otherwise, a sole requester is granted. If both request, the master selected by prio wins.
- At most one gnt per cycle.

Alignment check, evaluated on the granted request. Legal combinations:
- be=4'hF with addr[1:0]=0.
- be=4'h3 with addr[1:0]=0, or be=4'hC with addr[1:0]=2.
- be=4'h1 shifted left by addr[1:0].

Everything else is illegal, including be=0.

Per grant:
- Legal: mem_en=1. mem_we, mem_addr, mem_wdata and mem_be are driven from the granted master.
- Loads: set resp_sel to the master, resp_kind=read.
- Stores: complete on the grant cycle and produce no response.
- Illegal: mem_en=0, and resp_kind=error is set for that master.

Lock:
- A granted m1 request with m1_lock=1 sets locked.
- A granted m1 request with m1_lock=0 clears it.
- m1 dropping req does not clear it.
- The lock update applies even when the request is misaligned.

Idle outputs: when no grant, mem_en=0 and mem_* outputs are 0.

## Timing

- Reset values: mX_gnt, mX_rvalid, mX_err and mem_en are 0; all data outputs are 0; prio=0, locked=0, resp_sel=none.
- Assertion of reset takes effect immediately, mid-transaction included: a pending response is dropped and no rvalid or err follows.
- mX_gnt and mem_* are combinational from the inputs and registered state in the same cycle, gated low while reset=1.
- Response latency is exactly 1 cycle after gnt, for both rvalid and err. Only the master recorded in resp_sel sees it.
- Back-to-back grants every cycle are allowed. A response and a new grant in the same cycle are independent.
- A master's req held across cycles without gnt must not change its payload. The arbiter does not latch payloads.

## Test plan

- Single m0 load: m0 load, addr=0x0C, be=F, memory word 3 = 0xBBBBBBBB.
  - Cycle N: m0_gnt=1 and mem_en=1 with mem_addr=0xC.
  - Cycle N+1: m0_rvalid=1 and m0_rdata=0xBBBBBBBB; m1_rvalid stays 0.
- Round-robin: after reset, m0 and m1 both request loads continuously. Grants go m0, m1, m0, m1. Each rvalid reaches its own master one cycle after its gnt.
- Lock: m1 stores addr=0,4,8 with lock=1,1,0 while m0 requests throughout.
  - m0_gnt=0 for those three cycles.
  - m0 is granted in the cycle after the lock=0 grant.
- Misaligned: m0 store, addr=0x6, be=F → m0_gnt=1 with mem_en=0, then m0_err=1 next cycle with no rvalid. m0 byte store (sb), addr=0x8, be=1 → mem_en=1, mem_be=1.
- Reset mid-operation: assert reset one cycle after an m1 load grant, with locked=1.
  - m1_rvalid stays 0.
  - After release, m0 is granted first when both request.
- Store then load to the same word: m0 store addr=0x4, wdata=0xAAAAAAAA, be=F, then m1 load addr=0x4 the next cycle. m1_rdata=0xAAAAAAAA.
